// File: rtl/iomem_stream_mailbox.sv
// ---------------------------------------------------------------------------
// iomem_stream_mailbox
//
// Memory-mapped mailbox on the SoC iomem bus. CPU writes push words into a
// TX FIFO that an external valid/ready consumer drains. An external producer
// fills an RX FIFO that the CPU pops by reading.
//
// Register window (BASE_ADDR, 16 bytes, addr[1:0] ignored):
//   0x0 TXDATA  W: push wdata             R: 0
//   0x4 RXDATA  R: pop head (0 if empty)  W: ignored
//   0x8 STATUS  R: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                  [4] tx_overflow [5] rx_underflow [11:8] tx_count
//                  [19:16] rx_count
//   0xC CTRL    [0] irq_en (R/W); write bit1 = flush, bit2 = clear sticky
//
// Ports:
//   clk, reset                       system clock, sync active-high reset
//   iomem_valid/ready/wstrb/addr/
//   iomem_wdata/rdata                CPU native port (responder side)
//   tx_data/tx_valid/tx_ready        TX stream out (show-ahead head)
//   rx_data/rx_valid/rx_ready        RX stream in
//   irq                              registered irq_en & !rx_empty
// ---------------------------------------------------------------------------
module iomem_stream_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_access;

  logic [31:0]   r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp;
  logic [AW-1:0] r_tx_rp;
  logic [AW:0]   r_tx_cnt;

  logic [31:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp;
  logic [AW-1:0] r_rx_rp;
  logic [AW:0]   r_rx_cnt;

  logic          r_tx_ovf;
  logic          r_rx_unf;
  logic          r_irq_en;
  logic          r_irq;
  logic [31:0]   r_rdata;

  logic          w_sel;
  logic          w_wr;
  logic [1:0]    w_reg;
  logic          w_cpu_push;
  logic          w_cpu_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_clr;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_val;
  logic          w_unused_addr;

  // Byte offset within a word carries no meaning here.
  assign w_unused_addr = ^iomem_addr[1:0];

  assign w_sel = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr  = |iomem_wstrb;
  assign w_reg = iomem_addr[3:2];

  // Bus FSM: IDLE performs the access, ACK holds ready for exactly one cycle
  // and never looks at sel, so one request yields exactly one side effect.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          w_access    = ~reset;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign iomem_ready = (r_state == S_ACK);
  assign iomem_rdata = r_rdata;

  // Access decode
  assign w_cpu_push = w_access &&  w_wr && (w_reg == 2'd0);
  assign w_cpu_pop  = w_access && !w_wr && (w_reg == 2'd1);
  assign w_ctrl_wr  = w_access &&  w_wr && (w_reg == 2'd3);
  assign w_flush    = w_ctrl_wr && iomem_wdata[1];
  assign w_clr      = w_ctrl_wr && iomem_wdata[2];

  assign w_tx_full  = (r_tx_cnt == CNT_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CNT_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);

  // Full/empty are the pre-edge values, so a CPU push into a full TX FIFO is
  // dropped even if the stream pops in the same cycle, and a CPU pop of an
  // empty RX FIFO underflows even if the stream pushes in the same cycle.
  assign w_tx_push = w_cpu_push && !w_tx_full;
  assign w_tx_pop  = tx_valid && tx_ready;
  assign w_rx_push = rx_valid && rx_ready;
  assign w_rx_pop  = w_cpu_pop && !w_rx_empty;

  assign tx_data  = r_tx_mem[r_tx_rp];
  assign tx_valid = !w_tx_empty;
  assign rx_ready = !reset && !w_rx_full;
  assign irq      = r_irq;

  // TX FIFO control (flush wins over same-cycle stream traffic)
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= iomem_wdata;
  end

  // RX FIFO control
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push && !w_flush) r_rx_mem[r_rx_wp] <= rx_data;
  end

  // Sticky flags, CTRL and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_clr) begin
        r_tx_ovf <= 1'b0;
        r_rx_unf <= 1'b0;
      end else begin
        if (w_cpu_push && w_tx_full)  r_tx_ovf <= 1'b1;
        if (w_cpu_pop  && w_rx_empty) r_rx_unf <= 1'b1;
      end
      if (w_ctrl_wr) r_irq_en <= iomem_wdata[0];
      r_irq <= r_irq_en && !w_rx_empty;
    end
  end

  // Read data path
  always_comb begin
    w_status        = '0;
    w_status[0]     = w_tx_full;
    w_status[1]     = w_tx_empty;
    w_status[2]     = w_rx_full;
    w_status[3]     = w_rx_empty;
    w_status[4]     = r_tx_ovf;
    w_status[5]     = r_rx_unf;
    w_status[11:8]  = 4'(r_tx_cnt);
    w_status[19:16] = 4'(r_rx_cnt);
  end

  always_comb begin
    w_rd_val = '0;
    if (!w_wr) begin
      case (w_reg)
        2'd1:    if (!w_rx_empty) w_rd_val = r_rx_mem[r_rx_rp];
        2'd2:    w_rd_val = w_status;
        2'd3:    w_rd_val[0] = r_irq_en;
        default: w_rd_val = '0;
      endcase
    end
  end

  // rdata is only nonzero during the ACK cycle that follows the access.
  always_ff @(posedge clk) begin
    if (reset)         r_rdata <= '0;
    else if (w_access) r_rdata <= w_rd_val;
    else               r_rdata <= '0;
  end

endmodule
